// File: rtl/lfsr_engine_if.sv
// Register-file and job-control signals shared between lfsr_engine and its environment.
// The engine takes the master modport because it drives the register-file address/write side.
interface lfsr_engine_if;
    logic       start;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [4:0] internal_r_addr;
    logic [4:0] internal_w_addr;
    logic [7:0] internal_din;
    logic       internal_wr_en;

    modport master (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output internal_r_addr,
        output internal_w_addr,
        output internal_din,
        output internal_wr_en
    );

    modport slave (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  internal_r_addr,
        input  internal_w_addr,
        input  internal_din,
        input  internal_wr_en
    );
endinterface

// File: rtl/lfsr_engine.sv
// Fibonacci LFSR job engine: reads seed/taps/N from the register file, writes N states to slots 4..; LFSR_WRITEBACK_SEED_EN adds a final-state writeback to addr 0.
// Latency start->done = 4+N cycles (+1 with writeback); no backpressure, start is ignored while busy.
module lfsr_engine (
    input  logic         clk,
    input  logic         rst_n,
    lfsr_engine_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SEED,
        S_RD_TAPS,
        S_RD_CNT,
        S_STEP,
`ifdef LFSR_WRITEBACK_SEED_EN
        S_WB,
`endif
        S_DONE
    } state_t;

    // State that follows the last step (or an empty job).
`ifdef LFSR_WRITEBACK_SEED_EN
    localparam state_t S_TAIL = S_WB;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t     r_state;
    logic [7:0] r_lfsr;
    logic [7:0] r_taps;
    logic [4:0] r_cnt;
    logic [4:0] r_k;

    state_t     w_state_nxt;
    logic       w_fb;
    logic [7:0] w_next;
    logic [4:0] w_n_clamped;
    logic       w_last;
    logic       w_busy;
    logic       w_done;
    logic [4:0] w_r_addr;
    logic [4:0] w_w_addr;
    logic [7:0] w_din;
    logic       w_wr_en;

    assign w_fb        = ^(r_lfsr & r_taps);
    assign w_next      = {r_lfsr[6:0], w_fb};
    // Clamp keeps 4+k inside the 28 result slots.
    assign w_n_clamped = (bus.rd_data > 8'd28) ? 5'd28 : bus.rd_data[4:0];
    assign w_last      = (r_k == (r_cnt - 5'd1));

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_r_addr    = 5'd0;
        w_w_addr    = 5'd0;
        w_din       = 8'd0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_RD_SEED;
                end
            end
            S_RD_SEED: begin
                w_r_addr    = 5'd0;
                w_state_nxt = S_RD_TAPS;
            end
            S_RD_TAPS: begin
                w_r_addr    = 5'd1;
                w_state_nxt = S_RD_CNT;
            end
            S_RD_CNT: begin
                w_r_addr    = 5'd2;
                w_state_nxt = (w_n_clamped != 5'd0) ? S_STEP : S_TAIL;
            end
            S_STEP: begin
                w_wr_en  = 1'b1;
                w_w_addr = 5'd4 + r_k;
                w_din    = w_next;
                if (w_last) begin
                    w_state_nxt = S_TAIL;
                end
            end
`ifdef LFSR_WRITEBACK_SEED_EN
            S_WB: begin
                w_wr_en     = 1'b1;
                w_w_addr    = 5'd0;
                w_din       = r_lfsr;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lfsr  <= 8'd0;
            r_taps  <= 8'd0;
            r_cnt   <= 5'd0;
            r_k     <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_RD_SEED: begin
                    // An all-zero seed would lock the register at zero.
                    r_lfsr <= (bus.rd_data == 8'd0) ? 8'd1 : bus.rd_data;
                end
                S_RD_TAPS: begin
                    r_taps <= bus.rd_data;
                end
                S_RD_CNT: begin
                    r_cnt <= w_n_clamped;
                    r_k   <= 5'd0;
                end
                S_STEP: begin
                    r_lfsr <= w_next;
                    r_k    <= r_k + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy            = w_busy;
    assign bus.done            = w_done;
    assign bus.internal_r_addr = w_r_addr;
    assign bus.internal_w_addr = w_w_addr;
    assign bus.internal_din    = w_din;
    assign bus.internal_wr_en  = w_wr_en;

endmodule

// File: tb/tb_lfsr_engine.sv
// Directed bench for lfsr_engine with a behavioural register file; outputs sampled on the falling edge.
module tb_lfsr_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lfsr_engine_if bus();

    lfsr_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef LFSR_WRITEBACK_SEED_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic [7:0] mem [0:31];
    assign bus.rd_data = mem[bus.internal_r_addr];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0       = 0;
    int n_wr     = 0;
    int wr_a [64];
    int wr_d [64];
    int wr_c [64];
    int done_cyc;
    int bad_busy;
    int idle_after;
    logic [7:0] exp_d [0:27];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: advance to the falling edge, sample, and apply any write to the register file.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.internal_wr_en === 1'b1) begin
            if (n_wr < 64) begin
                wr_a[n_wr] = int'(bus.internal_w_addr);
                wr_d[n_wr] = int'(bus.internal_din);
                wr_c[n_wr] = cyc - t0;
            end
            n_wr++;
            mem[bus.internal_w_addr] = bus.internal_din;
        end
    endtask

    task automatic preload(input logic [7:0] seed, input logic [7:0] taps, input logic [7:0] n);
        mem[0] = seed;
        mem[1] = taps;
        mem[2] = n;
        for (int i = 3; i < 32; i++) mem[i] = 8'hEE;
        n_wr = 0;
    endtask

    task automatic run_job(input bit poke);
        t0       = cyc;
        bus.start = 1'b1;
        done_cyc = -1;
        bad_busy = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1) bus.start = 1'b0;
            if (poke && k == 2) bus.start = 1'b1;
            if (poke && k == 3) bus.start = 1'b0;
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.done === 1'b1) begin
                done_cyc = cyc - t0;
                break;
            end
        end
        tick();
        idle_after = (bus.busy === 1'b0 && bus.done === 1'b0 && bus.internal_wr_en === 1'b0) ? 1 : 0;
    endtask

    task automatic verify(input string tag, input int n_eff, input logic [7:0] seed_raw,
                          input logic [7:0] final_st);
        chk({tag, "_done"}, done_cyc, 4 + n_eff + WB);
        chk({tag, "_nwr"}, n_wr, n_eff + WB);
        for (int i = 0; i < n_eff && i < n_wr; i++) begin
            chk($sformatf("%s_a%0d", tag, i), wr_a[i], 4 + i);
            chk($sformatf("%s_d%0d", tag, i), wr_d[i], int'(exp_d[i]));
            chk($sformatf("%s_c%0d", tag, i), wr_c[i], 4 + i);
        end
        if (WB == 1 && n_wr > n_eff && n_eff < 64) begin
            chk({tag, "_wb_a"}, wr_a[n_eff], 0);
            chk({tag, "_wb_d"}, wr_d[n_eff], int'(final_st));
            chk({tag, "_wb_c"}, wr_c[n_eff], 4 + n_eff);
        end
        chk({tag, "_mem0"}, mem[0], (WB == 1) ? final_st : seed_raw);
        chk({tag, "_mem3"}, mem[3], 8'hEE);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_idle"}, idle_after, 1);
    endtask

    function automatic logic [7:0] lfsr_nx(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    initial begin
        logic [7:0] s;
        int nw;
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // Reset state
        tick(); tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wr_en", bus.internal_wr_en, 0);
        chk("rst_w_addr", bus.internal_w_addr, 0);
        chk("rst_r_addr", bus.internal_r_addr, 0);
        chk("rst_din", bus.internal_din, 0);
        rst_n = 1'b1;
        tick();

        // seed 01, taps B8, N=3
        preload(8'h01, 8'hB8, 8'd3);
        exp_d[0] = 8'h02; exp_d[1] = 8'h04; exp_d[2] = 8'h08;
        run_job(1'b0);
        verify("A", 3, 8'h01, 8'h08);

        // seed 80, N=2, with a start pulse while busy
        preload(8'h80, 8'hB8, 8'd2);
        exp_d[0] = 8'h01; exp_d[1] = 8'h02;
        run_job(1'b1);
        verify("B", 2, 8'h80, 8'h02);

        // zero seed is replaced by 01
        preload(8'h00, 8'hB8, 8'd1);
        exp_d[0] = 8'h02;
        run_job(1'b0);
        verify("C", 1, 8'h00, 8'h02);

        // longer run exercising feedback = 1
        preload(8'h01, 8'hB8, 8'd8);
        exp_d[0] = 8'h02; exp_d[1] = 8'h04; exp_d[2] = 8'h08; exp_d[3] = 8'h11;
        exp_d[4] = 8'h23; exp_d[5] = 8'h47; exp_d[6] = 8'h8E; exp_d[7] = 8'h1C;
        run_job(1'b0);
        verify("D", 8, 8'h01, 8'h1C);

        // different taps
        preload(8'hFF, 8'h8E, 8'd3);
        exp_d[0] = 8'hFE; exp_d[1] = 8'hFC; exp_d[2] = 8'hF9;
        run_job(1'b0);
        verify("E", 3, 8'hFF, 8'hF9);

        // N=40 clamps to 28 writes over slots 4..31
        preload(8'h01, 8'hB8, 8'd40);
        s = 8'h01;
        for (int i = 0; i < 28; i++) begin
            s = lfsr_nx(s, 8'hB8);
            exp_d[i] = s;
        end
        run_job(1'b0);
        verify("F", 28, 8'h01, exp_d[27]);

        // N=0: no step writes
        preload(8'h5A, 8'hB8, 8'd0);
        run_job(1'b0);
        verify("G", 0, 8'h5A, 8'h5A);

        // reset during STEP k=1 of an N=5 job
        preload(8'h01, 8'hB8, 8'd5);
        t0 = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("rj_pre_wr", bus.internal_wr_en, 1);
        chk("rj_pre_addr", bus.internal_w_addr, 5);
        rst_n = 1'b0;
        tick();
        chk("rj_busy", bus.busy, 0);
        chk("rj_done", bus.done, 0);
        chk("rj_wr_en", bus.internal_wr_en, 0);
        chk("rj_w_addr", bus.internal_w_addr, 0);
        chk("rj_r_addr", bus.internal_r_addr, 0);
        chk("rj_din", bus.internal_din, 0);
        nw = n_wr;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("rj_nwr_after", n_wr, nw);
        chk("rj_nwr", n_wr, 2);
        chk("rj_mem6", mem[6], 8'hEE);
        chk("rj_idle", bus.busy, 0);

        // job after reset starts cleanly
        preload(8'h01, 8'hB8, 8'd3);
        exp_d[0] = 8'h02; exp_d[1] = 8'h04; exp_d[2] = 8'h08;
        run_job(1'b0);
        verify("R", 3, 8'h01, 8'h08);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
